// File: rtl/apb_cmd_master_pkg.sv
// apb_cmd_master_pkg
//   Shared types and constants for the APB3 command initiator.
//   - apb_state_e : controller state encoding (IDLE, SETUP, ACCESS, RESP)
//   - APB_ADDR_W  : default APB address width
//   - APB_DATA_W  : default APB data width
//   - TMO_CNT_W   : width of the ACCESS-phase timeout counter
//                   (used only when APB_CMD_MASTER_TIMEOUT_EN is defined)
package apb_cmd_master_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int TMO_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_cmd_master_wdog.sv
// apb_cmd_master_wdog
//   ACCESS-phase wait counter. Counts cycles in which the slave is stalling
//   and flags expiry once the stall reaches LIMIT cycles.
//   Ports:
//     clk    : APB clock
//     rst    : synchronous active-high reset
//     clr    : clear the count (asserted the cycle before ACCESS starts)
//     en     : count this cycle (in ACCESS with pready low)
//     expire : this counted cycle is the LIMIT-th stall cycle
//   Only instantiated when APB_CMD_MASTER_TIMEOUT_EN is defined.
module apb_cmd_master_wdog
  import apb_cmd_master_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int CNT_W = TMO_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W:0] LIMIT_V = (CNT_W+1)'(LIMIT);
  localparam logic [CNT_W:0] ONE_V   = (CNT_W+1)'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   count_ext;

  assign count_ext = {1'b0, count_q};

  // Flag on the stall cycle that brings the count up to LIMIT, so the
  // controller can leave ACCESS on the following edge.
  assign expire = en && ((count_ext + ONE_V) >= LIMIT_V);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   APB3 initiator: takes one command at a time over a valid/ready channel,
//   runs the SETUP/ACCESS phases on APB, and returns read data and error
//   status over a valid/ready response channel.
//   Ports:
//     pclk, preset          : clock, synchronous active-high reset
//     cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//     cmd_write/addr/wdata  : command payload, sampled on acceptance
//     rsp_valid/rsp_ready   : response handshake
//     rsp_rdata/rsp_err     : read data (0 for writes), slave error/timeout
//     psel/penable/pwrite   : APB control
//     paddr/pwdata          : APB address / write data
//     prdata/pready/pslverr : APB slave returns (looked at only in ACCESS)
//     busy                  : high whenever not IDLE
//   Build option: APB_CMD_MASTER_TIMEOUT_EN adds an ACCESS-phase watchdog
//   that aborts after TIMEOUT_CYCLES stall cycles with rsp_err=1.
//
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | psel high, penable low, one cycle
//   ACCESS | psel and penable high, waiting for pready
//   RESP   | rsp_valid high, waiting for rsp_ready
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  apb_state_e        state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic tmo_clr;
  logic tmo_en;
  logic tmo_expire;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  apb_cmd_master_wdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (TMO_CNT_W)
  ) u_wdog (
    .clk    (pclk),
    .rst    (preset),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );
`else
  // No watchdog: ACCESS waits for pready indefinitely.
  logic unused_tmo;
  assign tmo_expire = 1'b0;
  assign unused_tmo = ^{tmo_clr, tmo_en, TIMEOUT_CYCLES};
`endif

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        tmo_clr = 1'b1;
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        tmo_en = ~pready;
        // pready wins over a watchdog expiry in the same cycle.
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          state_d     = ST_RESP;
        end else if (tmo_expire) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable   = (state_q == ST_ACCESS);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB3 initiator that turns single-word commands from an on-chip requester (debug bridge, DMA, test sequencer) into APB transactions toward peripheral slaves such as the timer block. It accepts one command at a time over a valid/ready handshake and drives the SETUP and ACCESS phases. It honours `pready` wait states and returns read data and error status over a valid/ready response channel.

## Interface
- `ADDR_W`, 32, APB address width
- `DATA_W`, 32, APB data width
- `TIMEOUT_CYCLES`, 255, maximum ACCESS-phase wait before forced abort; used only with the timeout macro
- `pclk  in  1  clock`
- `preset  in  1  reset, synchronous, active-high`
- `cmd_valid  in  1  command present`
- `cmd_ready  out  1  command accepted when high together with cmd_valid`
- `cmd_write  in  1  1 = write, 0 = read`
- `cmd_addr  in  ADDR_W  target address`
- `cmd_wdata  in  DATA_W  write data`
- `rsp_valid  out  1  response present`
- `rsp_ready  in  1  response consumed`
- `rsp_rdata  out  DATA_W  read data; 0 for writes`
- `rsp_err  out  1  pslverr or timeout`
- `psel, penable, pwrite  out  1  APB control`
- `paddr  out  ADDR_W`, `pwdata  out  DATA_W`
- `prdata  in  DATA_W`, `pready  in  1`, `pslverr  in  1`
- `busy  out  1  high in any state other than IDLE`

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE:** `cmd_ready=1`. On `cmd_valid`, latch write, addr and wdata into `pwrite`, `paddr` and `pwdata`, then go to SETUP.
- **SETUP:** `psel=1`, `penable=0`. Always go to ACCESS after one cycle.
- **ACCESS:** `psel=1`, `penable=1`. Stay while `pready=0`.
  - When `pready=1`: register `rsp_rdata` (`prdata` for reads, 0 for writes) and `rsp_err=pslverr`, then go to RESP.
- **RESP:** `psel=0`, `penable=0`, `rsp_valid=1`. Hold `rsp_*` stable until `rsp_ready`, then go to IDLE.
- `cmd_ready` is high only in IDLE. No command is accepted while a response is pending.
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through the final ACCESS cycle. They keep their last value in IDLE and RESP.
- `pready` and `pslverr` are ignored outside ACCESS.
- `cmd_*` inputs are ignored outside IDLE. Changing them has no effect on a transaction in flight.

## Timing
- Reset values: all outputs 0 except `cmd_ready`, which is 1 after the reset cycle (state IDLE). `paddr`, `pwdata` and `rsp_rdata` reset to 0.
- Zero-wait transaction:
  - Cycle 0: command accepted.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS with `pready` high.
  - Cycle 3: `rsp_valid` high.
  - If `rsp_ready` is already high in cycle 3, the block returns to IDLE in cycle 4.
  - Minimum four cycles per command.
- Each `pready`-low cycle adds exactly one ACCESS cycle.
- `preset` asserted in any state:
  - Next cycle is IDLE with `psel`, `penable` and `rsp_valid` at 0.
  - The in-flight transaction is dropped and no response is produced.
- `preset` has priority over every other input in the same cycle.
- `pslverr=1` together with `pready=0` is not an error and is ignored.
- The error is sampled only in the `pready=1` cycle.

## Configuration
- Macro: `APB_CMD_MASTER_TIMEOUT_EN`.
- **Defined:**
  - An 8–16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with `pready=0`.
  - When it reaches `TIMEOUT_CYCLES`, the next cycle enters RESP with `rsp_err=1` and `rsp_rdata=0`, and `psel`/`penable` drop.
  - A `pready` arriving in the same cycle as the limit wins: normal completion.
- **Undefined:** no counter; ACCESS waits indefinitely for `pready`.
- The port list is identical in both builds.

## Structure
- Package `apb_cmd_master_pkg`:
  - FSM state enum (IDLE, SETUP, ACCESS, RESP).
  - Default `ADDR_W`/`DATA_W` constants.
  - Timeout counter width constant.
- One sub-module, `apb_cmd_master_wdog`: the timeout counter with clear, enable and expire ports. It is instantiated only under `APB_CMD_MASTER_TIMEOUT_EN`.
- FSM and datapath registers live in the top module.

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF, `pready` tied 1:
  - SETUP at cycle 1, ACCESS at cycle 2 with `pwrite=1` and `pwdata=0xDEAD_BEEF`.
  - `rsp_valid` at cycle 3 with `rsp_err=0` and `rsp_rdata=0`.
- Read 0x0000_0004, slave holds `pready=0` for 3 cycles, then returns 0x1234_5678:
  - 4 ACCESS cycles with `paddr` stable.
  - `rsp_rdata=0x1234_5678`.
- Read with `pslverr=1` on the `pready` cycle → `rsp_err=1`; `pslverr=1` on a wait cycle only → `rsp_err=0`.
- `rsp_ready` held low 5 cycles:
  - `rsp_valid` and data held stable, `cmd_ready=0` throughout.
  - A `cmd_valid` pulse in that window is not accepted.
- `preset` asserted during ACCESS:
  - Next cycle `psel=0`, `penable=0`, `busy=0`, `cmd_ready=1`.
  - No `rsp_valid` ever appears for that command.
- With `APB_CMD_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`, `pready` stuck 0 → RESP after 8 wait cycles with `rsp_err=1`. Without the macro → still in ACCESS after 1000 cycles.
